// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: two producer queues (ALU, load),
// round-robin arbitration onto the single write port, and a pending-write
// scoreboard used by issue to detect RAW hazards.

// Small synchronous FIFO used for each producer queue.
module regfile_writeback_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   // Pointer update; reset empties the queue without touching the storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Entry storage.
   // NOTE: the storage array has no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

module regfile_writeback #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [ADDR_WIDTH-1:0]     alu_addr,
   input  logic [DATA_WIDTH-1:0]     alu_data,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [ADDR_WIDTH-1:0]     ld_addr,
   input  logic [DATA_WIDTH-1:0]     ld_data,
   input  logic                      issue_valid,
   input  logic [ADDR_WIDTH-1:0]     issue_addr,
   output logic                      write_enable,
   output logic [ADDR_WIDTH-1:0]     write_addr,
   output logic [DATA_WIDTH-1:0]     write_data,
   output logic [2**ADDR_WIDTH-1:0]  pending_mask
);

   localparam int ENT_W    = ADDR_WIDTH + DATA_WIDTH;
   localparam int NUM_REGS = 2**ADDR_WIDTH;

   typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_e;

   src_e                  last_grant;
   logic                  alu_push, alu_empty, alu_full, grant_alu;
   logic                  ld_push, ld_empty, ld_full, grant_ld;
   logic [ENT_W-1:0]      alu_head, ld_head;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   logic [NUM_REGS-1:0]   pending_next;

   // Writes to x0 complete the handshake but are dropped before the queue.
   assign alu_ready = !alu_full;
   assign ld_ready  = !ld_full;
   assign alu_push  = alu_valid && !alu_full && (alu_addr != '0);
   assign ld_push   = ld_valid  && !ld_full  && (ld_addr  != '0);

   regfile_writeback_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_q (
      .clk(clk), .rst(rst), .push(alu_push), .push_data({alu_addr, alu_data}),
      .pop(grant_alu), .head(alu_head), .empty(alu_empty), .full(alu_full)
   );

   regfile_writeback_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_ld_q (
      .clk(clk), .rst(rst), .push(ld_push), .push_data({ld_addr, ld_data}),
      .pop(grant_ld), .head(ld_head), .empty(ld_empty), .full(ld_full)
   );

   // Round-robin grant: a lone non-empty queue wins, ties go opposite last_grant.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      grant_alu = 1'b0;
      grant_ld  = 1'b0;
      win_addr  = ld_head[ENT_W-1:DATA_WIDTH];
      win_data  = ld_head[DATA_WIDTH-1:0];
      if (!alu_empty && (ld_empty || last_grant == SRC_LD)) begin
         grant_alu = 1'b1;
         win_addr  = alu_head[ENT_W-1:DATA_WIDTH];
         win_data  = alu_head[DATA_WIDTH-1:0];
      end else if (!ld_empty) begin
         grant_ld = 1'b1;
      end
   end

   // Scoreboard next state: clear the drained register, then apply issue so set wins.
   always_comb begin
      pending_next = pending_mask;
      if (grant_alu || grant_ld) pending_next[win_addr] = 1'b0;
      if (issue_valid)           pending_next[issue_addr] = 1'b1;
      pending_next[0] = 1'b0;
   end

   // Registered write port, arbitration history and scoreboard.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         last_grant   <= SRC_LD;
         pending_mask <= '0;
      end else begin
         pending_mask <= pending_next;
         write_enable <= grant_alu || grant_ld;
         if (grant_alu || grant_ld) begin
            write_addr <= win_addr;
            write_data <= win_data;
            last_grant <= grant_alu ? SRC_ALU : SRC_LD;
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector tables, hand-written
// corner sequences, and randomized traffic compared against a queue-based model.
module tb_regfile_writeback;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid = 1'b0, ld_valid = 1'b0, issue_valid = 1'b0;
   logic [4:0]  alu_addr = '0, ld_addr = '0, issue_addr = '0;
   logic [31:0] alu_data = '0, ld_data = '0;
   logic        alu_ready, ld_ready, write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] pending_mask;

   int vectors = 0;
   int miscompares = 0;

   regfile_writeback dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t        mq_alu[$];
   ent_t        mq_ld[$];
   bit          m_last_ld;
   bit          m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   bit          m_pend[32];
   bit          m_alu_acc, m_ld_acc;
   ent_t        obs[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq_alu.delete();
      mq_ld.delete();
      m_last_ld = 1'b1;
      m_we      = 1'b0;
      m_waddr   = '0;
      m_wdata   = '0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      foreach (m_pend[i]) m[i] = m_pend[i];
      return m;
   endfunction

   // One clock: check ready, advance the model with the current inputs, take the
   // edge, then compare the registered outputs 1 time unit later.
   task automatic tick();
      bit   alu_rdy, ld_rdy;
      ent_t e;
      alu_rdy = (mq_alu.size() < DEPTH);
      ld_rdy  = (mq_ld.size() < DEPTH);
      check("alu_ready", alu_ready, alu_rdy);
      check("ld_ready", ld_ready, ld_rdy);
      m_alu_acc = alu_valid && alu_rdy;
      m_ld_acc  = ld_valid && ld_rdy;
      m_we = 1'b0;
      if (mq_alu.size() > 0 && (mq_ld.size() == 0 || m_last_ld)) begin
         e = mq_alu.pop_front();
         m_last_ld = 1'b0;
         m_we = 1'b1;
      end else if (mq_ld.size() > 0) begin
         e = mq_ld.pop_front();
         m_last_ld = 1'b1;
         m_we = 1'b1;
      end
      if (m_we) begin
         m_waddr = e.addr;
         m_wdata = e.data;
         m_pend[e.addr] = 1'b0;
      end
      if (m_alu_acc && alu_addr != 0) mq_alu.push_back('{alu_addr, alu_data});
      if (m_ld_acc && ld_addr != 0)   mq_ld.push_back('{ld_addr, ld_data});
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
      @(posedge clk);
      #1;
      check("write_enable", write_enable, m_we);
      check("write_addr", write_addr, m_waddr);
      check("write_data", write_data, m_wdata);
      check("pending_mask", pending_mask, model_mask());
      if (write_enable) obs.push_back('{write_addr, write_data});
   endtask

   task automatic idle_inputs();
      alu_valid = 0; ld_valid = 0; issue_valid = 0;
      alu_addr = 0; ld_addr = 0; issue_addr = 0;
      alu_data = 0; ld_data = 0;
   endtask

   // Reset pulse placed between clock edges.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          reset_first;
      bit          av;
      logic [4:0]  aa;
      logic [31:0] ad;
      bit          lv;
      logic [4:0]  la;
      logic [31:0] ld;
      bit          exp_we;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int ld_cnt;
      int ld_seen;
      bit saw_full;

      // Single ALU write: latency of one edge after acceptance, then hold.
      tbl.push_back('{1, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0});
      tbl.push_back('{0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 1, 5'd5, 32'h1234});
      tbl.push_back('{0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 0, 5'd5, 32'h1234});
      // Contention: A0,L0,A1,L1,A2,L2 written back to back.
      tbl.push_back('{1, 1, 5'd1, 32'hA0A0_0000, 1, 5'd2, 32'h1D1D_0000, 0, 5'd0, 32'h0});
      tbl.push_back('{0, 1, 5'd3, 32'hA0A0_0001, 1, 5'd4, 32'h1D1D_0001, 1, 5'd1, 32'hA0A0_0000});
      tbl.push_back('{0, 1, 5'd5, 32'hA0A0_0002, 1, 5'd6, 32'h1D1D_0002, 1, 5'd2, 32'h1D1D_0000});
      tbl.push_back('{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd3, 32'hA0A0_0001});
      tbl.push_back('{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd4, 32'h1D1D_0001});
      tbl.push_back('{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 32'hA0A0_0002});
      tbl.push_back('{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd6, 32'h1D1D_0002});
      tbl.push_back('{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd6, 32'h1D1D_0002});

      // ---- reset behaviour ----
      idle_inputs();
      model_reset();
      #3;
      check("rst_we", write_enable, 1'b0);
      check("rst_pending", pending_mask, 32'h0);
      check("rst_alu_ready", alu_ready, 1'b1);
      check("rst_ld_ready", ld_ready, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_hold_we", write_enable, 1'b0);
      check("rst_hold_addr", write_addr, 5'd0);
      rst = 1'b1;
      repeat (3) tick();

      // ---- table-driven vectors ----
      foreach (tbl[i]) begin
         if (tbl[i].reset_first) do_reset();
         alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
         ld_valid  = tbl[i].lv; ld_addr  = tbl[i].la; ld_data  = tbl[i].ld;
         tick();
         check($sformatf("tbl%0d_we", i), write_enable, tbl[i].exp_we);
         check($sformatf("tbl%0d_addr", i), write_addr, tbl[i].exp_addr);
         check($sformatf("tbl%0d_data", i), write_data, tbl[i].exp_data);
      end
      idle_inputs();

      // ---- full load queue with held offers ----
      do_reset();
      obs.delete();
      ld_cnt = 0;
      saw_full = 0;
      for (int c = 0; c < 14; c++) begin
         alu_valid = 1; alu_addr = 5'd8; alu_data = 32'hAA00_0000 + c;
         ld_valid  = 1; ld_addr  = 5'd9; ld_data  = 32'h5500_0000 + ld_cnt;
         if (!ld_ready) saw_full = 1;
         tick();
         if (m_ld_acc) ld_cnt++;
      end
      idle_inputs();
      repeat (12) tick();
      check("ld_full_seen", saw_full, 1'b1);
      ld_seen = 0;
      foreach (obs[i]) begin
         if (obs[i].addr == 5'd9) begin
            check("ld_order", obs[i].data, 32'h5500_0000 + ld_seen);
            ld_seen++;
         end
      end
      check("ld_count", ld_seen, ld_cnt);

      // ---- scoreboard and x0 ----
      do_reset();
      issue_valid = 1; issue_addr = 5'd7;
      tick();
      issue_valid = 0;
      check("pend7_set", pending_mask[7], 1'b1);
      alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h77;
      tick();
      alu_valid = 0;
      check("pend7_queued", pending_mask[7], 1'b1);
      check("pend7_no_write_yet", write_enable, 1'b0);
      issue_valid = 1; issue_addr = 5'd7;
      tick();
      issue_valid = 0;
      check("pend7_write_we", write_enable, 1'b1);
      check("pend7_write_addr", write_addr, 5'd7);
      check("pend7_set_wins", pending_mask[7], 1'b1);
      alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h78;
      tick();
      alu_valid = 0;
      tick();
      check("pend7_cleared", pending_mask[7], 1'b0);
      check("pend7_second_write", write_data, 32'h78);
      alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hDEAD;
      issue_valid = 1; issue_addr = 5'd0;
      check("x0_ready", alu_ready, 1'b1);
      tick();
      idle_inputs();
      tick();
      check("x0_no_write", write_enable, 1'b0);
      check("x0_no_pending", pending_mask[0], 1'b0);

      // ---- async reset mid-burst ----
      do_reset();
      for (int c = 0; c < 3; c++) begin
         alu_valid = 1; alu_addr = 5'd10 + c; alu_data = 32'hC0 + c;
         ld_valid  = 1; ld_addr  = 5'd20 + c; ld_data  = 32'hD0 + c;
         issue_valid = 1; issue_addr = 5'd25 + c;
         tick();
      end
      idle_inputs();
      #3;
      rst = 1'b0;
      #1;
      check("arst_we", write_enable, 1'b0);
      check("arst_addr", write_addr, 5'd0);
      check("arst_data", write_data, 32'h0);
      check("arst_pending", pending_mask, 32'h0);
      check("arst_alu_ready", alu_ready, 1'b1);
      check("arst_ld_ready", ld_ready, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      obs.delete();
      repeat (5) tick();
      check("arst_no_writes", obs.size(), 0);

      // ---- randomized traffic against the model ----
      do_reset();
      for (int c = 0; c < 800; c++) begin
         alu_valid   = ($urandom_range(0, 3) != 0);
         alu_addr    = 5'($urandom_range(0, 7));
         alu_data    = $urandom;
         ld_valid    = ($urandom_range(0, 2) != 0);
         ld_addr     = 5'($urandom_range(0, 7));
         ld_data     = $urandom;
         issue_valid = ($urandom_range(0, 1) != 0);
         issue_addr  = 5'($urandom_range(0, 7));
         tick();
      end
      idle_inputs();
      repeat (10) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
